// File: rtl/pipe_ctrl_pkg.sv
// Shared types, opcode constants and decode helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pipe_ctrl_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  function automatic logic op_uses_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] op_ID,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic [6:0] op_IDEX,
  input  logic [4:0] rd_IDEX,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = op_uses_rs1(op_ID) && (rs1_ID == rd_IDEX);
    rs2_hit  = op_uses_rs2(op_ID) && (rs2_ID == rd_IDEX);
    // x0 never carries a real result, so a load to x0 cannot create a dependency.
    load_use = (op_IDEX == OPC_LOAD) && (rd_IDEX != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, EX redirects, and a multi-cycle divide
// wait with watchdog, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op_ID,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic [6:0]           op_IDEX,
  input  logic [2:0]           funct3_IDEX,
  input  logic [6:0]           funct7_IDEX,
  input  logic [4:0]           rd_IDEX,
  input  logic                 redirect_EX,
  input  logic                 md_done,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_stall,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 md_start,
  output logic                 md_timeout_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 state_dbg
);

  localparam int MDC_W = $clog2(MD_TIMEOUT) + 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

  pipe_ctrl_state_t state, state_nxt;
  logic [MDC_W-1:0] md_cycles, md_cycles_nxt;
  logic             timeout_err_q;
  logic             timeout_fire;
  logic             load_use;
  logic             md_req;

  hazard_detect u_hazard_detect (
    .op_ID    (op_ID),
    .rs1_ID   (rs1_ID),
    .rs2_ID   (rs2_ID),
    .op_IDEX  (op_IDEX),
    .rd_IDEX  (rd_IDEX),
    .load_use (load_use)
  );

  // Divide/remainder family: M-extension funct7 with funct3[2] set.
  assign md_req = (op_IDEX == OPC_OP) && (funct7_IDEX == FUNCT7_MULDIV) &&
                  (funct3_IDEX inside {3'b100, 3'b101, 3'b110, 3'b111});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      md_cycles     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      md_cycles     <= md_cycles_nxt;
      timeout_err_q <= timeout_err_q | timeout_fire;
    end
  end

  always_comb begin
    state_nxt     = state;
    md_cycles_nxt = md_cycles;
    timeout_fire  = 1'b0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_stall    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    md_start      = 1'b0;
    // Controls are forced quiet while reset is asserted, independent of the inputs.
    if (!reset) begin
      case (state)
        RUN: begin
          md_cycles_nxt = '0;
          if (md_req) begin
            md_start    = 1'b1;
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = MD_WAIT;
          end else if (redirect_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state_nxt     = RUN;
            md_cycles_nxt = '0;
          end else if (md_cycles == MD_LAST) begin
            // Watchdog: squash the divide by bubbling EX/MEM and let the pipe go.
            timeout_fire  = 1'b1;
            exmem_flush   = 1'b1;
            state_nxt     = RUN;
            md_cycles_nxt = '0;
          end else begin
            pc_stall      = 1'b1;
            ifid_stall    = 1'b1;
            idex_stall    = 1'b1;
            exmem_flush   = 1'b1;
            md_cycles_nxt = md_cycles + MDC_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (ifid_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign md_timeout_err = timeout_err_q | timeout_fire;
  assign state_dbg      = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 6;
  localparam int SAT  = 63;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OPIMM  = 7'b0010011;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op_id, op_idex, f7;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  logic redirect, md_done;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_start, md_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_wait;
  int m_cnt;
  bit m_err;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .op_ID(op_id), .rs1_ID(rs1), .rs2_ID(rs2),
    .op_IDEX(op_idex), .funct3_IDEX(f3), .funct7_IDEX(f7), .rd_IDEX(rd),
    .redirect_EX(redirect), .md_done(md_done),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .md_start(md_start), .md_timeout_err(md_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_start, md_timeout_err}
  function automatic logic [7:0] dut_vec();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_start, md_err};
  endfunction

  function automatic logic [7:0] model_vec();
    bit u1, u2, lu, mdr;
    if (reset) return 8'h00;
    u1  = !(op_id == LUI || op_id == AUIPC || op_id == JAL);
    u2  = (op_id == BRANCH || op_id == STORE || op_id == OP);
    lu  = (op_idex == LOAD) && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    mdr = (op_idex == OP) && (f7 == 7'h01) && (f3 >= 3'd4);
    if (m_wait) begin
      if (md_done)           return {7'b0000000, m_err};
      else if (m_cnt == TO-1) return 8'b0000_0101;
      else                   return {8'b1101_0100 | {7'b0, m_err}};
    end
    if (mdr)      return {8'b1101_0110 | {7'b0, m_err}};
    if (redirect) return {8'b0010_1000 | {7'b0, m_err}};
    if (lu)       return {8'b1100_1000 | {7'b0, m_err}};
    return {7'b0, m_err};
  endfunction

  // advance one clock; model absorbs the inputs present at the edge
  task automatic tick();
    logic [7:0] e;
    e = model_vec();
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[7] && m_stall < SAT) m_stall++;
      if (e[5] && m_flush < SAT) m_flush++;
      if (m_wait) begin
        if (md_done) begin m_wait = 0; m_cnt = 0; end
        else if (m_cnt == TO-1) begin m_wait = 0; m_cnt = 0; m_err = 1; end
        else m_cnt++;
      end else if (e[1]) begin
        m_wait = 1; m_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    op_id = LUI; rs1 = 0; rs2 = 0;
    op_idex = OP; f3 = 3'd0; f7 = 7'h00; rd = 0;
    redirect = 0; md_done = 0;
  endtask

  task automatic set_div();
    op_idex = OP; f7 = 7'h01; f3 = 3'd4; rd = 5'd3;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 8'h00 || stall_cnt !== 0 || flush_cnt !== 0 || state_dbg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ctl=%b sc=%0d fc=%0d st=%b required ctl=0 sc=0 fc=0 st=0",
               dut_vec(), stall_cnt, flush_cnt, state_dbg);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    op_idex = LOAD; rd = 5'd5; op_id = OP; rs1 = 5'd5; rs2 = 5'd1;
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 8'b1100_1000) begin
      n_fail++; $display("FAIL load_use_stall: got %b required 11001000", dut_vec());
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 8'h00 || stall_cnt !== 1) begin
      n_fail++; $display("FAIL load_use_after: ctl=%b sc=%0d required ctl=0 sc=1", dut_vec(), stall_cnt);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    do_reset();
    op_idex = LOAD; rd = 5'd0; op_id = OP; rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    n_tests++;
    if (pc_stall !== 1'b0 || idex_flush !== 1'b0) begin
      n_fail++; $display("FAIL load_x0: pc_stall=%b idex_flush=%b required 0 0", pc_stall, idex_flush);
    end
    tick();
    rd = 5'd5; op_id = LUI; rs1 = 5'd5; rs2 = 5'd5;
    @(negedge clk);
    n_tests++;
    if (pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL load_lui: pc_stall=%b required 0", pc_stall);
    end
    tick();
    op_id = STORE; rs1 = 5'd2; rs2 = 5'd5;
    @(negedge clk);
    n_tests++;
    if (pc_stall !== 1'b1 || ifid_stall !== 1'b1 || idex_flush !== 1'b1) begin
      n_fail++; $display("FAIL load_store_rs2: pc=%b ifid=%b idexf=%b required 1 1 1",
                         pc_stall, ifid_stall, idex_flush);
    end
    tick();
    op_id = OPIMM; rs1 = 5'd2; rs2 = 5'd5;
    @(negedge clk);
    n_tests++;
    if (pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL load_opimm_rs2: pc_stall=%b required 0", pc_stall);
    end
    tick();
  endtask

  task automatic test_redirect_priority();
    do_reset();
    op_idex = LOAD; rd = 5'd5; op_id = OP; rs1 = 5'd5; redirect = 1;
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 8'b0010_1000) begin
      n_fail++; $display("FAIL redirect_over_load: got %b required 00101000", dut_vec());
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      n_fail++; $display("FAIL redirect_counts: fc=%0d sc=%0d required fc=1 sc=0", flush_cnt, stall_cnt);
    end
    tick();
    set_div(); redirect = 1;
    @(negedge clk);
    n_tests++;
    if (md_start !== 1'b1 || ifid_flush !== 1'b0) begin
      n_fail++; $display("FAIL div_over_redirect: md_start=%b ifid_flush=%b required 1 0", md_start, ifid_flush);
    end
    tick();
    redirect = 1;
    @(negedge clk);
    n_tests++;
    if (ifid_flush !== 1'b0 || pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL redirect_in_wait: ifid_flush=%b pc_stall=%b required 0 1", ifid_flush, pc_stall);
    end
    redirect = 0; md_done = 1;
    tick();
    idle();
  endtask

  task automatic test_divide();
    int highs;
    do_reset();
    set_div();
    highs = 0;
    for (int c = 0; c < 7; c++) begin
      md_done = (c == 6);
      @(negedge clk);
      if (pc_stall) highs++;
      n_tests++;
      if (md_start !== (c == 0)) begin
        n_fail++; $display("FAIL div_start c%0d: md_start=%b required %b", c, md_start, (c == 0));
      end
      n_tests++;
      if ((c < 6 && dut_vec() !== {8'b1101_0100 | {6'b0, (c == 0), 1'b0}}) || (c == 6 && dut_vec() !== 8'h00)) begin
        n_fail++; $display("FAIL div_ctl c%0d: got %b", c, dut_vec());
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (highs != 6 || stall_cnt !== 6 || state_dbg !== 1'b0) begin
      n_fail++; $display("FAIL div_totals: highs=%0d sc=%0d st=%b required 6 6 0", highs, stall_cnt, state_dbg);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_div();
    tick();  // md_start cycle
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      n_tests++;
      if (c < TO-1 && (dut_vec() !== 8'b1101_0100)) begin
        n_fail++; $display("FAIL wait_c%0d: got %b required 11010100", c, dut_vec());
      end else if (c == TO-1 && dut_vec() !== 8'b0000_0101) begin
        n_fail++; $display("FAIL watchdog: got %b required 00000101", dut_vec());
      end
      tick();
    end
    idle();
    md_done = 1;
    @(negedge clk);
    n_tests++;
    if (dut_vec() !== 8'b0000_0001 || state_dbg !== 1'b0) begin
      n_fail++; $display("FAIL post_timeout: ctl=%b st=%b required 00000001 0", dut_vec(), state_dbg);
    end
    tick();
    md_done = 0;
    @(negedge clk);
    n_tests++;
    if (md_err !== 1'b1 || stall_cnt !== TO) begin
      n_fail++; $display("FAIL err_sticky: err=%b sc=%0d required 1 %0d", md_err, stall_cnt, TO);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_div();
    tick(); tick(); tick();
    @(negedge clk);
    reset = 1;
    #1;
    n_tests++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL reset_async_ctl: got %b required 0", dut_vec());
    end
    tick();
    idle();
    tick();
    reset = 0;
    @(negedge clk);
    n_tests++;
    if (state_dbg !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0 || md_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait: st=%b sc=%0d fc=%0d err=%b required 0 0 0 0",
                         state_dbg, stall_cnt, flush_cnt, md_err);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{LOAD, STORE, BRANCH, OP, LUI, AUIPC, JAL, OPIMM};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op_id    = ops[$urandom_range(0, 7)];
      rs1      = 5'($urandom_range(0, 5));
      rs2      = 5'($urandom_range(0, 5));
      op_idex  = ops[$urandom_range(0, 3)];
      f3       = 3'($urandom_range(0, 7));
      f7       = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'h00;
      rd       = 5'($urandom_range(0, 5));
      redirect = ($urandom_range(0, 4) == 0);
      md_done  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL rand_ctl c%0d: got %b required %b", c, dut_vec(), model_vec());
      end
      n_tests++;
      if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || state_dbg !== m_wait) begin
        n_fail++; $display("FAIL rand_cnt c%0d: sc=%0d fc=%0d st=%b required %0d %0d %b",
                           c, stall_cnt, flush_cnt, state_dbg, m_stall, m_flush, m_wait);
      end
      tick();
    end
    // long enough that both counters must have pinned at all-ones
    n_tests++;
    if (m_stall != SAT || stall_cnt !== CW'(SAT)) begin
      n_fail++; $display("FAIL saturate: sc=%0d model=%0d required %0d", stall_cnt, m_stall, SAT);
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    m_wait = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect_priority();
    test_divide();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
